// File: rtl/usb_pkg.sv
// Shared types and constants for the USB host transaction sequencer.
// PID values are in wire bit order as handed to the packet datapath.
package usb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND_TOK,
    SEND_DATA,
    WAIT_HS,
    WAIT_DATA,
    SEND_HS,
    DONE
  } txn_state_t;

  localparam logic [1:0] TRANS_NON = 2'd0;
  localparam logic [1:0] TRANS_IN  = 2'd1;
  localparam logic [1:0] TRANS_OUT = 2'd2;

  localparam logic [1:0] TYPE_NON  = 2'd0;
  localparam logic [1:0] TYPE_TOK  = 2'd1;
  localparam logic [1:0] TYPE_DATA = 2'd2;
  localparam logic [1:0] TYPE_HS   = 2'd3;

  localparam logic [7:0] OUTPID  = 8'h87;
  localparam logic [7:0] INPID   = 8'h96;
  localparam logic [7:0] DATAPID = 8'hC3;
  localparam logic [7:0] ACKPID  = 8'h4B;
  localparam logic [7:0] NAKPID  = 8'h5A;

  localparam logic [7:0] TIMEOUT_LEN   = 8'd255;
  localparam logic [3:0] MAX_RETRY_DEF = 4'd8;

  function automatic logic is_send(input txn_state_t s);
    return (s == SEND_TOK) || (s == SEND_DATA) || (s == SEND_HS);
  endfunction

  function automatic logic is_wait(input txn_state_t s);
    return (s == WAIT_HS) || (s == WAIT_DATA);
  endfunction

endpackage

// File: rtl/usb_timeout_ctr.sv
// Response timer: cleared outside wait states, counts up while enabled
// and parks at TIMEOUT, where it flags expiry.
module usb_timeout_ctr
  import usb_pkg::*;
#(
  parameter logic [7:0] TIMEOUT = TIMEOUT_LEN
) (
  input  logic i_clk,
  input  logic i_rst_b,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  logic [7:0] r_timer;

  always_ff @(posedge i_clk) begin
    if (!i_rst_b) begin
      r_timer <= '0;
    end else if (i_clr) begin
      r_timer <= '0;
    end else if (i_en && !o_expired) begin
      r_timer <= r_timer + 8'd1;
    end
  end

  assign o_expired = (r_timer == TIMEOUT);

endmodule

// File: rtl/usb_txn_sequencer.sv
// Host transaction sequencer: token, data and handshake phases for one
// IN/OUT request, with response timeout and bounded retries.
module usb_txn_sequencer
  import usb_pkg::*;
#(
  parameter logic [7:0] TIMEOUT   = TIMEOUT_LEN,
  parameter logic [3:0] MAX_RETRY = MAX_RETRY_DEF
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       txn_start,
  input  logic [1:0] txn_type,
  input  logic [3:0] txn_endp,
  output logic       tx_req,
  output logic [1:0] tx_type,
  output logic [7:0] tx_pid,
  output logic [3:0] tx_endp,
  input  logic       tx_done,
  output logic       rx_en,
  input  logic       rx_valid,
  input  logic [7:0] rx_pid,
  input  logic       rx_crc_ok,
  output logic       busy,
  output logic       txn_done,
  output logic       txn_ok,
  output logic [3:0] retry_cnt
);

  txn_state_t r_state;
  txn_state_t w_nxt;

  logic [1:0] r_type;
  logic       r_succ;
  logic [7:0] r_hs_pid;
  logic       r_tx_req;
  logic [1:0] r_tx_type;
  logic [7:0] r_tx_pid;
  logic [3:0] r_tx_endp;
  logic       r_rx_en;
  logic       r_busy;
  logic       r_txn_done;
  logic       r_txn_ok;
  logic [3:0] r_retry;

  logic       w_expired;
  logic       w_done;
  logic       w_accept;
  logic       w_fail;
  logic       w_ok;
  logic       w_succ;
  logic [7:0] w_hs_pid;
  logic [1:0] w_type_eff;
  logic [1:0] w_tx_type;
  logic [7:0] w_tx_pid;
  logic [3:0] w_retry_inc;

  usb_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .i_clk     (clk),
    .i_rst_b   (rst_b),
    .i_clr     (!is_wait(r_state)),
    .i_en      (is_wait(r_state)),
    .o_expired (w_expired)
  );

  // Only a completion for a packet actually being requested counts.
  assign w_done      = tx_done && r_tx_req;
  assign w_retry_inc = (r_retry == 4'hF) ? 4'hF : r_retry + 4'd1;
  assign w_type_eff  = w_accept ? txn_type : r_type;

  always_comb begin
    w_nxt    = r_state;
    w_accept = 1'b0;
    w_fail   = 1'b0;
    w_ok     = 1'b0;
    w_succ   = r_succ;
    w_hs_pid = r_hs_pid;
    unique case (r_state)
      IDLE: begin
        if (txn_start &&
            (txn_type == TRANS_IN || txn_type == TRANS_OUT)) begin
          w_nxt    = SEND_TOK;
          w_accept = 1'b1;
        end
      end
      SEND_TOK: begin
        if (w_done) begin
          w_nxt = (r_type == TRANS_OUT) ? SEND_DATA : WAIT_DATA;
        end
      end
      SEND_DATA: begin
        if (w_done) w_nxt = WAIT_HS;
      end
      WAIT_HS: begin
        if (rx_valid) begin
          if (rx_crc_ok && rx_pid == ACKPID) begin
            w_nxt = DONE;
            w_ok  = 1'b1;
          end else begin
            w_fail = 1'b1;
          end
        end else if (w_expired) begin
          w_fail = 1'b1;
        end
      end
      WAIT_DATA: begin
        if (rx_valid) begin
          if (!rx_crc_ok) begin
            w_nxt    = SEND_HS;
            w_hs_pid = NAKPID;
            w_succ   = 1'b0;
          end else if (rx_pid == DATAPID) begin
            w_nxt    = SEND_HS;
            w_hs_pid = ACKPID;
            w_succ   = 1'b1;
          end else begin
            w_fail = 1'b1;
          end
        end else if (w_expired) begin
          w_fail = 1'b1;
        end
      end
      SEND_HS: begin
        if (w_done) begin
          if (r_succ) begin
            w_nxt = DONE;
            w_ok  = 1'b1;
          end else begin
            w_fail = 1'b1;
          end
        end
      end
      DONE:    w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
    if (w_fail) begin
      w_nxt = (w_retry_inc == MAX_RETRY) ? DONE : SEND_TOK;
    end
  end

  always_comb begin
    w_tx_type = TYPE_NON;
    w_tx_pid  = 8'h00;
    unique case (w_nxt)
      SEND_TOK: begin
        w_tx_type = TYPE_TOK;
        w_tx_pid  = (w_type_eff == TRANS_OUT) ? OUTPID : INPID;
      end
      SEND_DATA: begin
        w_tx_type = TYPE_DATA;
        w_tx_pid  = DATAPID;
      end
      SEND_HS: begin
        w_tx_type = TYPE_HS;
        w_tx_pid  = w_hs_pid;
      end
      default: begin
        w_tx_type = TYPE_NON;
        w_tx_pid  = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_state    <= IDLE;
      r_type     <= TRANS_NON;
      r_succ     <= 1'b0;
      r_hs_pid   <= 8'h00;
      r_tx_req   <= 1'b0;
      r_tx_type  <= TYPE_NON;
      r_tx_pid   <= 8'h00;
      r_tx_endp  <= 4'h0;
      r_rx_en    <= 1'b0;
      r_busy     <= 1'b0;
      r_txn_done <= 1'b0;
      r_txn_ok   <= 1'b0;
      r_retry    <= 4'h0;
    end else begin
      r_state   <= w_nxt;
      r_succ    <= w_succ;
      r_hs_pid  <= w_hs_pid;
      if (w_accept) begin
        r_type    <= txn_type;
        r_tx_endp <= txn_endp;
      end
      // A one-cycle request gap separates back-to-back packets.
      r_tx_req   <= is_send(w_nxt) && !w_done;
      r_tx_type  <= w_tx_type;
      r_tx_pid   <= w_tx_pid;
      r_rx_en    <= is_wait(w_nxt);
      r_busy     <= (w_nxt != IDLE) && (w_nxt != DONE);
      r_txn_done <= (w_nxt == DONE);
      if (w_accept) r_txn_ok <= 1'b0;
      else if (w_ok) r_txn_ok <= 1'b1;
      if (w_accept) r_retry <= 4'h0;
      else if (w_fail) r_retry <= w_retry_inc;
    end
  end

  assign tx_req    = r_tx_req;
  assign tx_type   = r_tx_type;
  assign tx_pid    = r_tx_pid;
  assign tx_endp   = r_tx_endp;
  assign rx_en     = r_rx_en;
  assign busy      = r_busy;
  assign txn_done  = r_txn_done;
  assign txn_ok    = r_txn_ok;
  assign retry_cnt = r_retry;

endmodule
